and_op_arbiter: RTL
===================

# and_op_arbiter

Round-robin arbiter and sequencer that shares one flag-gated, registered AND datapath among NUM_REQ requesters. The datapath computes c = a & b and registers it on the clock edge where its flag input is high. This block grants one requester at a time and latches that requester's operands. It drives the datapath's a/b/flag inputs for exactly one cycle, captures the registered result, and returns it to the granted requester with a one-cycle valid pulse. It sits between requester logic and the datapath instance, on the same clock.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8; grant index width is clog2(NUM_REQ).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
- pi_req  input  NUM_REQ  per-requester request level; bit i belongs to requester i.
- pi_a  input  NUM_REQ  operand a of requester i; held stable while pi_req[i] is high.
- pi_b  input  NUM_REQ  operand b of requester i; held stable while pi_req[i] is high.
- po_ack  output  NUM_REQ  one-cycle pulse; operands of requester i were accepted.
- po_c_valid  output  NUM_REQ  one-cycle pulse; po_c_data holds requester i's result.
- po_c_data  output  1  returned result; meaningful only while some po_c_valid bit is high.
- po_dp_a  output  1  to datapath operand a.
- po_dp_b  output  1  to datapath operand b.
- po_dp_flag  output  1  to datapath flag; high for exactly one cycle per operation.
- pi_dp_c  input  1  registered result from the datapath.
- po_busy  output  1  high whenever the state is not IDLE.

## Operation
- All outputs are registered.
- Reset value of every output is 0. State resets to IDLE. The last-grant pointer resets to NUM_REQ-1, so requester 0 has first priority.
- States are IDLE, ISSUE, WAIT and DONE.
- Arbitration is evaluated at the clock edge only while the state is IDLE or DONE and pi_req != 0:
  - Winner: first set bit of pi_req, searching upward from last_grant+1, modulo NUM_REQ.
  - At that edge, latch the winner index, pi_a[idx] and pi_b[idx]; update last_grant to idx; go to ISSUE.
- IDLE or DONE with pi_req == 0: go to (or stay in) IDLE.
- ISSUE (one cycle):
  - po_ack[idx]=1, po_dp_flag=1, po_dp_a/po_dp_b = latched operands.
  - Next state: WAIT.
- WAIT (one cycle):
  - po_dp_flag=0; po_dp_a/po_dp_b return to 0.
  - pi_dp_c is valid in this cycle and is captured at the edge ending WAIT.
  - Next state: DONE.
- DONE (one cycle):
  - po_c_valid[idx]=1 and po_c_data = captured pi_dp_c.
  - Arbitration runs at the edge ending DONE, so back-to-back operations need no IDLE cycle.
- pi_req is ignored in ISSUE and WAIT.
- A requester deasserts pi_req after seeing po_ack. If it holds pi_req high, it is treated as a new request at the next arbitration point.
- At most one bit of po_ack is high in any cycle; the same holds for po_c_valid.
- Asynchronous reset mid-operation:
  - All outputs drop to 0 immediately and the state returns to IDLE.
  - The in-flight operation is discarded and no po_c_valid is issued for it.
  - The pointer returns to NUM_REQ-1.
- This block does not drive the datapath reset.

## Timing
- Edge E0: request arbitrated.
- Cycle C1 (ISSUE): po_ack and po_dp_flag high.
- Edge E1: datapath registers a & b.
- Cycle C2 (WAIT): pi_dp_c valid.
- Edge E2: result captured.
- Cycle C3 (DONE): po_c_valid high. Result latency is 3 cycles from the arbitrating edge.
- Sustained throughput is one operation per 3 cycles when requests are continuous.
- An idle gap of k cycles before a request adds exactly k cycles; there is no extra penalty.
- po_busy is high in C1 through C3. It is low in C4 if no new request arrived by E3.
- A request asserted in the cycle immediately after its own po_ack is eligible at the next DONE edge.

## Test plan
- Reset: rst_n low mid-cycle with requests pending -> all outputs 0 without waiting for a clock edge; po_busy=0.
- Single request: pi_req=4'b0100, a[2]=1, b[2]=1 -> po_ack=4'b0100 in C1; po_dp_flag=1, po_dp_a=1, po_dp_b=1 in C1; po_c_valid=4'b0100 and po_c_data=1 in C3. Repeat with b[2]=0 -> po_c_data=0.
- Full contention: pi_req=4'b1111 held after reset -> po_ack order 0,1,2,3,0, one pulse every 3 cycles, with no IDLE cycle between operations.
- Pointer fairness: last grant=1 and pi_req=4'b1010 -> next grant goes to 3, then 1.
- Back-to-back: pi_req[1] re-raised during WAIT -> ISSUE follows DONE directly; po_busy stays 1 throughout.
- Reset during WAIT: operation in flight for requester 2 -> no po_c_valid after rst_n release. With pi_req=4'b0101 still pending, the first grant after release is requester 0.

Source files
------------

// File: rtl/and_op_arbiter.sv
// and_op_arbiter: round-robin arbiter that time-shares one registered, flag-gated AND datapath.
// One operation runs at a time: ISSUE drives the datapath, WAIT captures its result, DONE returns it.
module and_op_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] pi_req,
    input  logic [NUM_REQ-1:0] pi_a,
    input  logic [NUM_REQ-1:0] pi_b,
    output logic [NUM_REQ-1:0] po_ack,
    output logic [NUM_REQ-1:0] po_c_valid,
    output logic               po_c_data,
    output logic               po_dp_a,
    output logic               po_dp_b,
    output logic               po_dp_flag,
    input  logic               pi_dp_c,
    output logic               po_busy
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_nx;
    logic [IW-1:0]      last, last_nx, win, j;
    logic               found;
    logic [NUM_REQ-1:0] ack_nx, valid_nx;
    logic               c_nx, a_nx, b_nx, flag_nx;

    // Rotating priority: first requester above the last grant, wrapping at NUM_REQ.
    always_comb begin
        win = '0;
        j = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = IW'((int'(last) + i) % NUM_REQ);
            if (!found && pi_req[j]) begin
                win = j;
                found = 1'b1;
            end
        end
    end

    // The last-grant pointer doubles as the index of the operation in flight.
    always_comb begin
        state_nx = state;
        last_nx = last;
        ack_nx = '0;
        valid_nx = '0;
        c_nx = 1'b0;
        a_nx = 1'b0;
        b_nx = 1'b0;
        flag_nx = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                state_nx = found ? ISSUE : IDLE;
                if (found) begin
                    last_nx = win;
                    ack_nx[win] = 1'b1;
                    flag_nx = 1'b1;
                    a_nx = pi_a[win];
                    b_nx = pi_b[win];
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                state_nx = DONE;
                valid_nx[last] = 1'b1;
                c_nx = pi_dp_c;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last <= IW'(NUM_REQ - 1);
            po_ack <= '0;
            po_c_valid <= '0;
            po_c_data <= 1'b0;
            po_dp_a <= 1'b0;
            po_dp_b <= 1'b0;
            po_dp_flag <= 1'b0;
            po_busy <= 1'b0;
        end else begin
            state <= state_nx;
            last <= last_nx;
            po_ack <= ack_nx;
            po_c_valid <= valid_nx;
            po_c_data <= c_nx;
            po_dp_a <= a_nx;
            po_dp_b <= b_nx;
            po_dp_flag <= flag_nx;
            po_busy <= state_nx != IDLE;
        end
    end
endmodule
